// File: rtl/result_display_driver.sv
// Captures valid 16-bit ALU results and shows them on a 4-digit common-anode
// multiplexed display, updating only at frame edges. Optional macro: RESULT_DISPLAY_LEAD_BLANK_EN.
module result_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result_in,
    input  logic        result_valid,
    input  logic        freeze,
    output logic [15:0] shown,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        overwrite
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [15:0]      pending_val_q, pending_val_d;
    logic             pending_q, pending_d;
    logic [15:0]      shown_q, shown_d;
    logic             overwrite_q, overwrite_d;

    logic wrap, frame_edge, capture, apply;

    // Segment patterns are g..a, active low.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        wrap       = (refresh_cnt_q == CNT_MAX);
        frame_edge = wrap && (digit_idx_q == 2'd3);
        capture    = result_valid && !freeze;
        apply      = frame_edge && pending_q && !freeze;

        refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
        digit_idx_d   = wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        pending_val_d = pending_val_q;
        pending_d     = pending_q;
        shown_d       = shown_q;
        overwrite_d   = overwrite_q;

        // Apply reads the old pending value, so a same-edge capture is never lost.
        if (apply) begin
            shown_d   = pending_val_q;
            pending_d = 1'b0;
        end
        if (capture) begin
            pending_val_d = result_in;
            pending_d     = 1'b1;
            if (pending_q && !apply)
                overwrite_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
            pending_q     <= 1'b0;
            shown_q       <= 16'h0000;
            overwrite_q   <= 1'b0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            pending_q     <= pending_d;
            shown_q       <= shown_d;
            overwrite_q   <= overwrite_d;
        end
    end

    always_ff @(posedge clk) begin
        pending_val_q <= pending_val_d;
    end

    assign shown     = shown_q;
    assign overwrite = overwrite_q;

    always_comb begin
        an_n              = 4'b1111;
        an_n[digit_idx_q] = 1'b0;
        seg_n             = hex7(shown_q[{digit_idx_q, 2'b00} +: 4]);
`ifdef RESULT_DISPLAY_LEAD_BLANK_EN
        // A digit is blank when it and every more-significant nibble are zero.
        case (digit_idx_q)
            2'd1: if (shown_q[15:4] == 12'h000) begin an_n = 4'b1111; seg_n = 7'b1111111; end
            2'd2: if (shown_q[15:8] == 8'h00)   begin an_n = 4'b1111; seg_n = 7'b1111111; end
            2'd3: if (shown_q[15:12] == 4'h0)   begin an_n = 4'b1111; seg_n = 7'b1111111; end
            default: ;
        endcase
`endif
    end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with REFRESH_DIV=4 (16-cycle frame).
module tb_result_display_driver;

    logic        clk;
    logic        reset;
    logic [15:0] result_in;
    logic        result_valid;
    logic        freeze;
    logic [15:0] shown;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        overwrite;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    result_display_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
        .freeze(freeze), .shown(shown), .an_n(an_n), .seg_n(seg_n), .overwrite(overwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc counts edges since the last reset edge; edges with cyc%16==0 are frame edges.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse(input logic [15:0] v);
        result_in = v;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] an_exp [4];
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
        do_reset();
        checks++; if (shown !== 16'h0000) begin errors++; $display("FAIL reset_shown got %h exp %h", shown, 16'h0000); end
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL reset_overwrite got %b exp 0", overwrite); end
        checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", an_n); end
        checks++; if (seg_n !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b exp 1000000", seg_n); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 4 == 3) begin
                checks++;
                if (an_n !== an_exp[k / 4]) begin errors++; $display("FAIL scan_an_hold k=%0d got %b exp %b", k, an_n, an_exp[k / 4]); end
            end
            if (k % 4 == 0) begin
                checks++;
`ifdef RESULT_DISPLAY_LEAD_BLANK_EN
                if (k != 16 && an_n !== 4'b1111) begin errors++; $display("FAIL scan_an k=%0d got %b exp 1111", k, an_n); end
                if (k == 16 && an_n !== 4'b1110) begin errors++; $display("FAIL scan_an k=%0d got %b exp 1110", k, an_n); end
`else
                if (an_n !== an_exp[(k / 4) % 4]) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an_n, an_exp[(k / 4) % 4]); end
`endif
            end
        end
        checks++; if (seg_n !== 7'b1000000) begin errors++; $display("FAIL reset_seg16 got %b exp 1000000", seg_n); end
    endtask

    task automatic test_reset_discard();
        do_reset();
        wait_to(2);
        pulse(16'h4444);
        wait_to(5);
        do_reset();
        wait_to(16);
        checks++; if (shown !== 16'h0000) begin errors++; $display("FAIL discard_shown got %h exp %h", shown, 16'h0000); end
    endtask

    task automatic test_tear_free();
        do_reset();
        wait_to(4);
        pulse(16'h12AF);
        wait_to(15);
        checks++; if (shown !== 16'h0000) begin errors++; $display("FAIL tear_hold got %h exp %h", shown, 16'h0000); end
        tick();
        checks++; if (shown !== 16'h12AF) begin errors++; $display("FAIL tear_shown got %h exp %h", shown, 16'h12AF); end
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0001110) begin errors++; $display("FAIL tear_d0 got %b/%b exp 1110/0001110", an_n, seg_n); end
        wait_to(20);
        checks++; if (an_n !== 4'b1101 || seg_n !== 7'b0001000) begin errors++; $display("FAIL tear_d1 got %b/%b exp 1101/0001000", an_n, seg_n); end
        wait_to(24);
        checks++; if (an_n !== 4'b1011 || seg_n !== 7'b0100100) begin errors++; $display("FAIL tear_d2 got %b/%b exp 1011/0100100", an_n, seg_n); end
        wait_to(28);
        checks++; if (an_n !== 4'b0111 || seg_n !== 7'b1111001) begin errors++; $display("FAIL tear_d3 got %b/%b exp 0111/1111001", an_n, seg_n); end
    endtask

    task automatic test_overwrite();
        do_reset();
        wait_to(2);
        pulse(16'h0001);
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL ovw_first got %b exp 0", overwrite); end
        wait_to(6);
        pulse(16'h0002);
        checks++; if (overwrite !== 1'b1) begin errors++; $display("FAIL ovw_set got %b exp 1", overwrite); end
        wait_to(16);
        checks++; if (shown !== 16'h0002) begin errors++; $display("FAIL ovw_shown got %h exp %h", shown, 16'h0002); end
        wait_to(40);
        checks++; if (overwrite !== 1'b1) begin errors++; $display("FAIL ovw_sticky got %b exp 1", overwrite); end
        do_reset();
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL ovw_reset got %b exp 0", overwrite); end
    endtask

    task automatic test_freeze();
        do_reset();
        wait_to(2);
        freeze = 1'b1;
        pulse(16'hBEEF);
        wait_to(16);
        checks++; if (shown !== 16'h0000) begin errors++; $display("FAIL frz_blocked got %h exp %h", shown, 16'h0000); end
        freeze = 1'b0;
        wait_to(32);
        checks++; if (shown !== 16'h0000) begin errors++; $display("FAIL frz_no_pending got %h exp %h", shown, 16'h0000); end
        wait_to(33);
        pulse(16'hBEEF);
        wait_to(47);
        checks++; if (shown !== 16'h0000) begin errors++; $display("FAIL frz_pre_edge got %h exp %h", shown, 16'h0000); end
        tick();
        checks++; if (shown !== 16'hBEEF) begin errors++; $display("FAIL frz_release got %h exp %h", shown, 16'hBEEF); end
        wait_to(50);
        pulse(16'h7777);
        freeze = 1'b1;
        wait_to(64);
        checks++; if (shown !== 16'hBEEF) begin errors++; $display("FAIL frz_hold_apply got %h exp %h", shown, 16'hBEEF); end
        freeze = 1'b0;
        wait_to(80);
        checks++; if (shown !== 16'h7777) begin errors++; $display("FAIL frz_retained got %h exp %h", shown, 16'h7777); end
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL frz_overwrite got %b exp 0", overwrite); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wait_to(5);
        pulse(16'h1111);
        wait_to(15);
        pulse(16'h2222);
        checks++; if (shown !== 16'h1111) begin errors++; $display("FAIL sim_shown got %h exp %h", shown, 16'h1111); end
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL sim_overwrite got %b exp 0", overwrite); end
        wait_to(31);
        checks++; if (shown !== 16'h1111) begin errors++; $display("FAIL sim_hold got %h exp %h", shown, 16'h1111); end
        tick();
        checks++; if (shown !== 16'h2222) begin errors++; $display("FAIL sim_next got %h exp %h", shown, 16'h2222); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wait_to(8);
        result_valid = 1'b1;
        result_in = 16'hAAAA; tick();
        result_in = 16'hBBBB; tick();
        result_in = 16'hC3C3; tick();
        result_valid = 1'b0;
        wait_to(16);
        checks++; if (shown !== 16'hC3C3) begin errors++; $display("FAIL b2b_last got %h exp %h", shown, 16'hC3C3); end
        checks++; if (overwrite !== 1'b1) begin errors++; $display("FAIL b2b_overwrite got %b exp 1", overwrite); end
    endtask

    task automatic test_blanking();
        do_reset();
        wait_to(3);
        pulse(16'h0005);
        wait_to(16);
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0010010) begin errors++; $display("FAIL blank_d0 got %b/%b exp 1110/0010010", an_n, seg_n); end
        for (int d = 1; d < 4; d++) begin
            wait_to(16 + 4 * d);
            checks++;
`ifdef RESULT_DISPLAY_LEAD_BLANK_EN
            if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin errors++; $display("FAIL blank_d%0d got %b/%b exp 1111/1111111", d, an_n, seg_n); end
`else
            if (an_n[d] !== 1'b0 || seg_n !== 7'b1000000) begin errors++; $display("FAIL blank_d%0d got %b/%b exp digit low/1000000", d, an_n, seg_n); end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        result_in = 16'h0000;
        result_valid = 1'b0;
        freeze = 1'b0;
        test_reset();
        test_reset_discard();
        test_tear_free();
        test_overwrite();
        test_freeze();
        test_simultaneous();
        test_back_to_back();
        test_blanking();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
